// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline:
// forwarding, load-use stall, branch flush and data-memory wait FSM.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [1:0]       resultsrc_e,
    input  logic             pcsrc_e,
    input  logic [4:0]       rd_m,
    input  logic             regwrite_m,
    input  logic             memop_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_w,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nx;
    logic          req_nx;
    logic          err_nx;
    logic          tmo;
    logic          mem_busy;
    logic          lw_stall;
    logic          unused_ok;

    assign unused_ok = resultsrc_e[1];

    // The current REQ cycle is the TIMEOUT-th one without an ack.
    assign tmo = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            mem_req <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nx;
            tcnt    <= tcnt_nx;
            mem_req <= req_nx;
            mem_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tcnt_nx  = '0;
        req_nx   = mem_req;
        err_nx   = mem_err;
        unique case (state)
            IDLE: begin
                if (memop_m) begin
                    state_nx = REQ;
                    req_nx   = 1'b1;
                end
            end
            REQ: begin
                tcnt_nx = tcnt + 1'b1;
                if (mem_ack) begin
                    state_nx = DONE;
                    req_nx   = 1'b0;
                end else if (tmo) begin
                    state_nx = DONE;
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    // DONE is deliberately not busy so M/W captures the read data.
    assign mem_busy = ((state == IDLE) && memop_m) || (state == REQ);

    assign lw_stall = resultsrc_e[0] && (rd_e != 5'd0)
                   && ((rd_e == rs1_d) || (rd_e == rs2_d));

    assign stall_f = mem_busy || lw_stall;
    assign stall_d = mem_busy || lw_stall;
    assign stall_e = mem_busy;
    assign stall_m = mem_busy;
    assign flush_w = mem_busy;
    assign flush_e = !mem_busy && (lw_stall || pcsrc_e);
    assign flush_d = !mem_busy && pcsrc_e;

    always_comb begin
        forward_a_e = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e)) begin
            forward_a_e = 2'b10;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e)) begin
            forward_a_e = 2'b01;
        end
    end

    always_comb begin
        forward_b_e = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e)) begin
            forward_b_e = 2'b10;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e)) begin
            forward_b_e = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_f && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline: F, D, E, M, W stages separated by the F/D, D/E, E/M and M/W pipeline registers.
- Combinational: EX operand forwarding, load-use stall, branch flush.
- Sequential: a data-memory handshake FSM that freezes F..M and bubbles the M/W register while a load or store in M waits for memory acknowledge, guarded by a timeout counter.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
TIMEOUT, 16, max cycles in REQ without mem_ack before the error path is taken (>=1).
CNT_W, 32, width of stall_cycles counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rs1_d  in  5  D-stage source register 1
rs2_d  in  5  D-stage source register 2
rs1_e  in  5  E-stage source register 1
rs2_e  in  5  E-stage source register 2
rd_e  in  5  E-stage destination register
resultsrc_e  in  2  E-stage result select; bit0=1 means load
pcsrc_e  in  1  branch/jump taken, resolved in E
rd_m  in  5  M-stage destination register
regwrite_m  in  1  M-stage register write enable
memop_m  in  1  load or store present in M
rd_w  in  5  W-stage destination register
regwrite_w  in  1  W-stage register write enable
mem_ack  in  1  data memory completion strobe
mem_req  out  1  data memory request, registered
forward_a_e  out  2  source A select: 00=regfile, 01=W result, 10=M aluresult
forward_b_e  out  2  source B select, same encoding
stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register
flush_d, flush_e, flush_w  out  1 each  load a bubble into F/D, D/E and M/W respectively
mem_err  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with stall_f=1

Behaviour:
Reset, asynchronous:
- FSM goes to IDLE; timeout counter, mem_req, mem_err and stall_cycles all go to 0.
- All combinational outputs then evaluate to 0, given idle inputs.

Memory FSM states: IDLE, REQ, DONE.
- IDLE: if memop_m=1, go to REQ and set mem_req=1 at that edge.
- REQ: mem_req=1; timeout counter increments each cycle.
  - mem_ack=1 goes to DONE and clears mem_req.
  - If the counter reaches TIMEOUT with no ack, go to DONE, set mem_err=1 (sticky until rst) and clear mem_req.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as an ack: no error.
- DONE: exactly 1 cycle, then IDLE; the counter clears.
- mem_ack outside REQ is ignored.
- Minimum memory-op cost is 3 cycles (IDLE-detect, REQ, DONE).

Signals:
- mem_busy = (IDLE & memop_m) | REQ. DONE is not busy, so M advances at the end of DONE and the M/W register captures read data.
- lw_stall = resultsrc_e[0] & (rd_e!=0) & (rd_e==rs1_d | rd_e==rs2_d).

Stall and flush equations:
- stall_f = stall_d = mem_busy | lw_stall
- stall_e = stall_m = mem_busy
- flush_w = mem_busy
- flush_e = ~mem_busy & (lw_stall | pcsrc_e)
- flush_d = ~mem_busy & pcsrc_e

Priority: mem_busy overrides branch and load-use handling, because E is frozen; the branch is taken on the first non-busy cycle.

Forwarding (per source; rs1_e shown, rs2_e identical):
- 10 if regwrite_m & rd_m!=0 & rd_m==rs1_e
- else 01 if regwrite_w & rd_w!=0 & rd_w==rs1_e
- else 00
- M has priority over W when both match.

stall_cycles: increments on each clock with stall_f=1; holds at all-ones.

Reset asserted mid-REQ: mem_req drops immediately (asynchronously); no ack is expected afterwards.

Test Plan:
- Forwarding: rd_m=5 with regwrite_m=1, rd_w=5 with regwrite_w=1, rs1_e=5 -> forward_a_e=10. Drop regwrite_m -> 01. Set rs1_e=0 -> 00.
- Load-use: resultsrc_e=01, rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1, stall_e=0, for 1 cycle. With rd_e=0 -> no stall.
- Memory wait: memop_m=1, mem_ack arrives on the 3rd REQ cycle -> mem_req high 3 cycles; stall_f..m and flush_w high 4 cycles; DONE cycle shows all 0; stall_cycles=4.
- Timeout, TIMEOUT=4, no ack -> mem_req high 4 cycles, then mem_err=1 and stays 1. Late mem_ack ignored.
- Branch during memory wait: pcsrc_e=1 while in REQ -> flush_d=flush_e=0; after ack, flush_d=flush_e=1 in the DONE cycle.
- Asynchronous reset mid-REQ -> mem_req=0 and stall_cycles=0 immediately, FSM in IDLE; normal operation resumes after rst deasserts.
